// File: rtl/led_matrix_scanner_pkg.sv
// Shared defaults and scan state encoding for the LED matrix scanner.
package led_matrix_scanner_pkg;

    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_SCAN_TIME  = 1024;
    localparam int DEF_BLANK_TIME = 16;
    localparam int DEF_BRIGHT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: writes go to the back buffer, reads
// come from the front buffer, swap flips which one is which.
module led_frame_buffer #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW  = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    logic            front_q;
    logic [COLS-1:0] mem_q [2][ROWS];
    logic            wr_ok;

    assign wr_ok = wr_en && (int'(wr_row) < ROWS);

    // The write targets the pre-swap back buffer even on a swap edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            if (wr_ok) begin
                mem_q[~front_q][wr_row] <= wr_data;
            end
            if (swap) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_data = mem_q[front_q][rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scanner with blanking gap, global PWM
// brightness and frame-boundary buffer swap.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int SCAN_TIME  = DEF_SCAN_TIME,
    parameter int BLANK_TIME = DEF_BLANK_TIME,
    parameter int BRIGHT_W   = DEF_BRIGHT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic [ROWS-1:0]         led_row,
    output logic [COLS-1:0]         led_col
);

    localparam int RW   = $clog2(ROWS);
    localparam int TMAX = (SCAN_TIME > BLANK_TIME) ? SCAN_TIME : BLANK_TIME;
    localparam int TW   = $clog2(TMAX);

    localparam logic [TW-1:0] STEP       = TW'(SCAN_TIME >> BRIGHT_W);
    localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_TIME - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TIME - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    if (SCAN_TIME % (1 << BRIGHT_W) != 0) begin : g_chk_scan
        $error("SCAN_TIME must be a multiple of 2**BRIGHT_W");
    end
    if (ROWS < 2 || COLS < 1 || BLANK_TIME < 1) begin : g_chk_dims
        $error("ROWS>=2, COLS>=1 and BLANK_TIME>=1 are required");
    end

    scan_state_t         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [RW-1:0]       row_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic                pend_q, pend_d;
    logic                swap_do, fs_d;
    logic [TW-1:0]       thr;
    logic [ROWS-1:0]     led_row_d;
    logic [COLS-1:0]     led_col_d;
    logic [COLS-1:0]     rd_data;

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_fb (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (swap_do),
        .rd_row  (row_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        row_d    = cur_row;
        bright_d = bright_q;
        swap_do  = 1'b0;
        fs_d     = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            timer_d = '0;
            row_d   = '0;
            swap_do = pend_q && (state_q == ST_IDLE);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    timer_d = '0;
                    row_d   = '0;
                    fs_d    = 1'b1;
                    swap_do = pend_q;
                end
                ST_BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        state_d  = ST_DRIVE;
                        timer_d  = '0;
                        bright_d = brightness;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (timer_q == SCAN_LAST) begin
                        state_d = ST_BLANK;
                        timer_d = '0;
                        if (cur_row == ROW_LAST) begin
                            row_d   = '0;
                            fs_d    = 1'b1;
                            swap_do = pend_q;
                        end else begin
                            row_d = cur_row + 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A request arriving on the swap edge waits for the next boundary.
        pend_d    = swap_do ? swap_req : (pend_q | swap_req);
        thr       = TW'(bright_d) * STEP;
        led_row_d = '0;
        led_col_d = '0;
        if (state_d == ST_DRIVE) begin
            led_row_d = ROWS'(1) << row_d;
            if (timer_d < thr) begin
                led_col_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bright_q    <= '0;
            pend_q      <= 1'b0;
            cur_row     <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            led_row     <= '0;
            led_col     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bright_q    <= bright_d;
            pend_q      <= pend_d;
            cur_row     <= row_d;
            swap_ack    <= swap_do;
            frame_start <= fs_d;
            led_row     <= led_row_d;
            led_col     <= led_col_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised bench for led_matrix_scanner against a frame-position model.
module tb_led_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SCAN  = 16;
    localparam int BLANK = 2;
    localparam int BW    = 2;
    localparam int RP    = SCAN + BLANK;
    localparam int FP    = ROWS * RP;
    localparam int STEP  = SCAN >> BW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic [BW-1:0]   brightness = '0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_row = '0;
    logic [COLS-1:0] wr_data = '0;
    logic            swap_req = 1'b0;
    logic            swap_ack;
    logic            frame_start;
    logic [1:0]      cur_row;
    logic [ROWS-1:0] led_row;
    logic [COLS-1:0] led_col;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SCAN_TIME  (SCAN),
        .BLANK_TIME (BLANK),
        .BRIGHT_W   (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .brightness  (brightness),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .cur_row     (cur_row),
        .led_row     (led_row),
        .led_col     (led_col)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position m_t inside the frame decides everything.
    bit              m_run = 1'b0;
    bit              m_pend = 1'b0;
    bit              m_front = 1'b0;
    int              m_t = 0;
    int              m_bq = 0;
    logic [COLS-1:0] m_buf [2][ROWS];
    logic [ROWS-1:0] e_row = '0;
    logic [COLS-1:0] e_col = '0;
    logic [1:0]      e_cur = '0;
    logic            e_fs = 1'b0;
    logic            e_ack = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit wrap, swp, drv;
        int row, off;
        if (rst) begin
            m_run = 0; m_pend = 0; m_front = 0; m_t = 0; m_bq = 0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++) m_buf[b][r] = '0;
            e_row = '0; e_col = '0; e_cur = '0; e_fs = 0; e_ack = 0;
        end else begin
            wrap = m_run && en && (m_t == FP - 1);
            swp  = m_pend && (!m_run || wrap);
            if (wr_en && int'(wr_row) < ROWS)
                m_buf[m_front ? 0 : 1][wr_row] = wr_data;
            if (swp) begin
                m_front = !m_front;
                m_pend = swap_req;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
            if (m_run && en && (m_t % RP == BLANK - 1)) m_bq = int'(brightness);
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FP;
            end
            row = m_t / RP;
            off = m_t % RP;
            drv = m_run && (off >= BLANK);
            e_ack = swp;
            e_fs  = m_run && (m_t == 0);
            e_cur = m_run ? 2'(row) : 2'd0;
            e_row = drv ? 4'(1 << row) : 4'd0;
            e_col = (drv && (off - BLANK) < m_bq * STEP) ? m_buf[m_front][row] : 4'd0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("led_row", int'(led_row), int'(e_row));
            check("led_col", int'(led_col), int'(e_col));
            check("cur_row", int'(cur_row), int'(e_cur));
            check("frame_start", int'(frame_start), int'(e_fs));
            check("swap_ack", int'(swap_ack), int'(e_ack));
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk_on = 1'b1;
        tick(2);
        check("idle_row", int'(led_row), 0);
        check("idle_fs", int'(frame_start), 0);

        en = 1'b1;
        tick(1);
        check("start_fs", int'(frame_start), 1);
        check("start_blank", int'(led_row), 0);
        tick(1);
        check("blank2_fs", int'(frame_start), 0);
        tick(1);
        check("row0_drive", int'(led_row), 1);
        tick(18);
        check("row1_drive", int'(led_row), 2);

        brightness = 2'd3;
        wr_en = 1'b1;
        wr_row = 2'd0; wr_data = 4'b1010; tick(1);
        wr_row = 2'd1; wr_data = 4'b0101; tick(1);
        wr_row = 2'd2; wr_data = 4'b1111; tick(1);
        wr_row = 2'd3; wr_data = 4'b0001; tick(1);
        wr_en = 1'b0;
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FP + 5; i++) begin
            tick(1);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_frame_start", int'(found), 1);
        check("ack_with_fs", int'(swap_ack), 1);
        tick(2);
        check("row0_col_on", int'(led_col), 10);
        tick(11);
        check("row0_col_t11", int'(led_col), 10);
        tick(1);
        check("row0_col_off", int'(led_col), 0);
        tick(6);
        check("row1_sel", int'(led_row), 2);
        check("row1_col", int'(led_col), 5);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) brightness = 2'($urandom_range(0, 3));
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_row   = 2'($urandom_range(0, 3));
            wr_data  = 4'($urandom_range(0, 15));
            swap_req = ($urandom_range(0, 39) == 0);
            if (en) en = ($urandom_range(0, 399) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        wr_en = 1'b0;
        swap_req = 1'b0;

        en = 1'b0;
        tick(3);
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        check("idle_req_edge", int'(swap_ack), 0);
        tick(1);
        check("idle_swap_ack", int'(swap_ack), 1);

        en = 1'b1;
        brightness = 2'd3;
        tick(5);
        check("pre_rst_row", int'(led_row), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_row", int'(led_row), 0);
        check("async_rst_cur", int'(cur_row), 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("post_rst_row", int'(led_row), 1);
        check("post_rst_col", int'(led_col), 0);
        tick(FP + 10);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
